// File: rtl/realign_pkg.sv
// Shared types and helpers for the RV32IC fetch realignment stage.
package realign_pkg;

    typedef enum logic {EMPTY, HALF} buf_state_t;

    typedef logic [15:0] half_t;

    localparam int HALF_BYTES = 2;

    // Complete internal state of the realigner, kept in one struct so it can be probed as a unit.
    typedef struct packed {
        buf_state_t  buf_state;
        logic        skip_low;
        half_t       buf_h;
        logic [31:0] buf_pc;
    } realign_state_t;

    function automatic logic is_compressed(input half_t h);
        return h[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/instr_out_reg.sv
// Output pipeline register for realigned instructions; flush invalidates it.
module instr_out_reg (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        in_is_c,
    output logic        advance,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_is_c,
    input  logic        out_ready
);

    // Handshake: a transfer happens on a cycle where valid & ready are both high;
    // valid and its payload are held unchanged until that transfer completes.
    assign advance = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
            out_is_c  <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (advance) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_instr <= in_instr;
                out_pc    <= in_pc;
                out_is_c  <= in_is_c;
            end
        end
    end

endmodule

// File: rtl/instr_realigner.sv
// Splits word-aligned fetch data into aligned 16/32-bit RV32IC instructions,
// carrying one residual halfword across word boundaries.
module instr_realigner
    import realign_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_addr,
    input  logic [31:0] fetch_data,
    output logic        fetch_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_is_c,
    input  logic        instr_ready
);

    realign_state_t st_q, st_d;

    logic        advance;
    logic        hold_half;
    logic        accept;
    logic        emit;
    logic        emit_c;
    logic [31:0] emit_instr;
    logic [31:0] emit_pc;
    logic [31:0] word_hi_pc;
    half_t       word_lo;
    half_t       word_hi;
    logic        redirect_unused;

    assign redirect_unused = ^{redirect_pc[31:2], redirect_pc[0]};

    assign word_lo    = fetch_data[15:0];
    assign word_hi    = fetch_data[31:16];
    assign word_hi_pc = fetch_addr + 32'(HALF_BYTES);

    // A buffered compressed halfword is a complete instruction, so no new word is taken that cycle.
    assign hold_half   = (st_q.buf_state == HALF) && is_compressed(st_q.buf_h);
    assign fetch_ready = advance & ~flush & ~hold_half;
    assign accept      = fetch_valid & fetch_ready;

    always_comb begin
        st_d       = st_q;
        emit       = 1'b0;
        emit_instr = '0;
        emit_pc    = '0;
        emit_c     = 1'b0;
        if (flush) begin
            st_d.buf_state = EMPTY;
            st_d.skip_low  = redirect_pc[1];
        end else if (advance) begin
            unique case (st_q.buf_state)
                EMPTY: begin
                    if (accept) begin
                        if (st_q.skip_low) begin
                            st_d.skip_low = 1'b0;
                            if (is_compressed(word_hi)) begin
                                emit       = 1'b1;
                                emit_instr = {16'b0, word_hi};
                                emit_pc    = word_hi_pc;
                                emit_c     = 1'b1;
                            end else begin
                                st_d.buf_h     = word_hi;
                                st_d.buf_pc    = word_hi_pc;
                                st_d.buf_state = HALF;
                            end
                        end else if (is_compressed(word_lo)) begin
                            emit           = 1'b1;
                            emit_instr     = {16'b0, word_lo};
                            emit_pc        = fetch_addr;
                            emit_c         = 1'b1;
                            st_d.buf_h     = word_hi;
                            st_d.buf_pc    = word_hi_pc;
                            st_d.buf_state = HALF;
                        end else begin
                            emit       = 1'b1;
                            emit_instr = fetch_data;
                            emit_pc    = fetch_addr;
                        end
                    end
                end
                HALF: begin
                    if (hold_half) begin
                        emit           = 1'b1;
                        emit_instr     = {16'b0, st_q.buf_h};
                        emit_pc        = st_q.buf_pc;
                        emit_c         = 1'b1;
                        st_d.buf_state = EMPTY;
                    end else if (accept) begin
                        // Straddling 32-bit instruction: low half buffered, high half from this word.
                        emit        = 1'b1;
                        emit_instr  = {word_lo, st_q.buf_h};
                        emit_pc     = st_q.buf_pc;
                        st_d.buf_h  = word_hi;
                        st_d.buf_pc = word_hi_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q <= '{buf_state: EMPTY, skip_low: 1'b0, buf_h: '0, buf_pc: '0};
        end else begin
            st_q <= st_d;
        end
    end

    instr_out_reg u_out_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (flush),
        .in_valid  (emit),
        .in_instr  (emit_instr),
        .in_pc     (emit_pc),
        .in_is_c   (emit_c),
        .advance   (advance),
        .out_valid (instr_valid),
        .out_instr (instr),
        .out_pc    (instr_pc),
        .out_is_c  (instr_is_c),
        .out_ready (instr_ready)
    );

endmodule

// File: tb/tb_instr_realigner.sv
// Bench for instr_realigner: directed cycle table, reset corner case, and a
// randomized run scored against a halfword-stream reference model.
module tb_instr_realigner;
    import realign_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic [31:0] fetch_data = '0;
    logic        fetch_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_is_c;
    logic        instr_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_realigner dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .fetch_valid (fetch_valid),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .fetch_ready (fetch_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_is_c  (instr_is_c),
        .instr_ready (instr_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- directed cycle table ----------------
    typedef struct {
        logic        flush;
        logic [31:0] redirect;
        logic        fv;
        logic [31:0] addr;
        logic [31:0] data;
        logic        ready;
        logic        exp_fr;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        logic        exp_c;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fl, input logic [31:0] rd, input logic fv,
                                input logic [31:0] a, input logic [31:0] d, input logic rdy,
                                input logic fr, input logic v, input logic [31:0] ei,
                                input logic [31:0] ep, input logic ec);
        vec_t r;
        r.flush = fl; r.redirect = rd; r.fv = fv; r.addr = a; r.data = d; r.ready = rdy;
        r.exp_fr = fr; r.exp_valid = v; r.exp_instr = ei; r.exp_pc = ep; r.exp_c = ec;
        return r;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        half_t       h;
        logic [31:0] pc;
    } hw_t;

    hw_t         hq[$];
    logic [64:0] exp_q[$];
    logic        skip_model = 1'b0;
    bit          model_on = 1'b0;
    bit          mon_fetch_hs = 1'b0;
    bit          mon_flush = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] stall_instr, stall_pc;
    logic        stall_c;
    logic [64:0] mon_e;

    function automatic logic comp(input half_t h);
        return h[1:0] != 2'b11;
    endfunction

    // Turn the halfword stream into instructions in program order.
    task automatic parse_stream();
        while (hq.size() > 0) begin
            if (comp(hq[0].h)) begin
                exp_q.push_back({16'b0, hq[0].h, hq[0].pc, 1'b1});
                void'(hq.pop_front());
            end else if (hq.size() >= 2) begin
                exp_q.push_back({hq[1].h, hq[0].h, hq[0].pc, 1'b0});
                void'(hq.pop_front());
                void'(hq.pop_front());
            end else begin
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && model_on) begin
            if (flush) begin
                checks++;
                if (fetch_ready) begin
                    errors++;
                    $display("FAIL flush_ready: got 1 expected 0");
                end
            end
            if (instr_valid && !instr_ready) begin
                checks++;
                if (fetch_ready) begin
                    errors++;
                    $display("FAIL stall_ready: got 1 expected 0");
                end
            end
            if (stall_prev) begin
                check("stall_valid", 32'(instr_valid), 32'd1);
                check("stall_instr", instr, stall_instr);
                check("stall_pc", instr_pc, stall_pc);
                check("stall_c", 32'(instr_is_c), 32'(stall_c));
            end
            stall_prev  = instr_valid & ~instr_ready & ~flush;
            stall_instr = instr;
            stall_pc    = instr_pc;
            stall_c     = instr_is_c;

            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_unexpected: got instr 0x%08h pc 0x%08h expected none", instr, instr_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rand_instr", instr, mon_e[64:33]);
                    check("rand_pc", instr_pc, mon_e[32:1]);
                    check("rand_c", 32'(instr_is_c), 32'(mon_e[0]));
                end
            end
            mon_flush    = flush;
            mon_fetch_hs = fetch_valid & fetch_ready;
            if (flush) begin
                hq.delete();
                exp_q.delete();
                skip_model = redirect_pc[1];
            end else if (fetch_valid && fetch_ready) begin
                if (!skip_model)
                    hq.push_back('{fetch_data[15:0], fetch_addr});
                hq.push_back('{fetch_data[31:16], fetch_addr + 32'd2});
                skip_model = 1'b0;
                parse_stream();
            end
        end
    end

    function automatic half_t rand_half();
        half_t h;
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
        else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
        return h;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] cur_addr;
        logic [31:0] cur_data;
        bit          have_word;

        // Cycle table: inputs driven for one cycle, outputs checked mid-cycle.
        vecs.push_back(mk(0, 0, 1, 32'h0, 32'h00B30513, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h4, 32'h45054585, 1, 1, 1, 32'h00B30513, 32'h0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h8, 32'h05134585, 1, 0, 1, 32'h4585, 32'h4, 1));
        vecs.push_back(mk(0, 0, 1, 32'h8, 32'h05134585, 1, 1, 1, 32'h4505, 32'h6, 1));
        vecs.push_back(mk(0, 0, 1, 32'hC, 32'hABCD00B3, 1, 1, 1, 32'h4585, 32'h8, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 32'h00B30513, 32'hA, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 32'hABCD, 32'hE, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h102, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h100, 32'h45851234, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 32'h4585, 32'h102, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h104, 32'h45054585, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h4585, 32'h104, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h4585, 32'h104, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h4585, 32'h104, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 32'h4585, 32'h104, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 32'h4505, 32'h106, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h110, 32'h00B30513, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h200, 0, 0, 0, 1, 0, 1, 32'h00B30513, 32'h110, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));

        // Reset and reset values.
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("reset_valid", 32'(instr_valid), 32'd0);
        check("reset_instr", instr, 32'd0);
        check("reset_pc", instr_pc, 32'd0);
        check("reset_c", 32'(instr_is_c), 32'd0);
        check("reset_fetch_ready", 32'(fetch_ready), 32'd1);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            flush       = vecs[i].flush;
            redirect_pc = vecs[i].redirect;
            fetch_valid = vecs[i].fv;
            fetch_addr  = vecs[i].addr;
            fetch_data  = vecs[i].data;
            instr_ready = vecs[i].ready;
            @(negedge clk);
            check($sformatf("vec%0d_fetch_ready", i), 32'(fetch_ready), 32'(vecs[i].exp_fr));
            check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_instr", i), instr, vecs[i].exp_instr);
                check($sformatf("vec%0d_pc", i), instr_pc, vecs[i].exp_pc);
                check($sformatf("vec%0d_c", i), 32'(instr_is_c), 32'(vecs[i].exp_c));
            end
        end

        // Reset asserted while a halfword is buffered and the output is valid.
        @(posedge clk);
        #1;
        flush = 1'b0; fetch_valid = 1'b1; fetch_addr = 32'h108; fetch_data = 32'h05134585; instr_ready = 1'b1;
        @(negedge clk);
        check("rst_seq_fetch_ready", 32'(fetch_ready), 32'd1);
        @(posedge clk);
        #1 fetch_valid = 1'b0;
        @(negedge clk);
        check("rst_seq_pre_valid", 32'(instr_valid), 32'd1);
        check("rst_seq_pre_instr", instr, 32'h4585);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(instr_valid), 32'd0);
        check("rst_async_instr", instr, 32'd0);
        check("rst_async_pc", instr_pc, 32'd0);
        check("rst_async_state", 32'(dut.st_q.buf_state), 32'(EMPTY));
        @(posedge clk);
        #1;
        reset_n = 1'b1; fetch_valid = 1'b1; fetch_addr = 32'h20; fetch_data = 32'h00B30513;
        @(negedge clk);
        check("rst_after_fetch_ready", 32'(fetch_ready), 32'd1);
        @(posedge clk);
        #1 fetch_valid = 1'b0;
        @(negedge clk);
        check("rst_after_valid", 32'(instr_valid), 32'd1);
        check("rst_after_instr", instr, 32'h00B30513);
        check("rst_after_pc", instr_pc, 32'h20);
        check("rst_after_c", 32'(instr_is_c), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_after_drain", 32'(instr_valid), 32'd0);

        // Randomized run against the reference model.
        @(posedge clk);
        #1;
        model_on = 1'b1; flush = 1'b1; redirect_pc = 32'h200; fetch_valid = 1'b0; instr_ready = 1'b1;
        cur_addr = 32'h200;
        cur_data = '0;
        have_word = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (mon_flush) begin
                cur_addr  = redirect_pc & ~32'd3;
                have_word = 1'b0;
            end else if (mon_fetch_hs) begin
                cur_addr  = cur_addr + 32'd4;
                have_word = 1'b0;
            end
            if (!have_word) begin
                cur_data  = {rand_half(), rand_half()};
                have_word = 1'b1;
            end
            flush = ($urandom_range(0, 39) == 0);
            if (flush) redirect_pc = 32'h200 + 32'($urandom_range(0, 255)) * 32'd2;
            fetch_valid = ($urandom_range(0, 3) != 0);
            fetch_addr  = cur_addr;
            fetch_data  = cur_data;
            instr_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        flush = 1'b0; fetch_valid = 1'b0; instr_ready = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        model_on = 1'b0;
        check("rand_drain_left", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_realigner.md
# instr_realigner

Fetch-side realignment stage for RV32IC. It accepts word-aligned 32-bit fetch words and emits one architecturally aligned instruction per handshake, either 16-bit compressed or 32-bit. A one-halfword residual buffer covers 32-bit instructions that straddle a word boundary. It sits between the fetch interface and the decode/compressed-expansion stage, which consumes its registered output.

## Interface
- No parameters. Widths are fixed: XLEN = 32, halfword = 16.
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  redirect request; discards all buffered and in-flight state
- redirect_pc  in  32  target PC on flush; only bit 1 is used internally
- fetch_valid  in  1  fetch_data/fetch_addr are valid
- fetch_addr  in  32  word address of fetch_data; bits [1:0] are 0
- fetch_data  in  32  instruction word, little-endian halfwords
- fetch_ready  out  1  word accepted this cycle when fetch_valid & fetch_ready
- instr_valid  out  1  registered instruction is valid
- instr  out  32  instruction; for compressed, bits [31:16] = 0
- instr_pc  out  32  PC of instr
- instr_is_c  out  1  instr is 16-bit compressed
- instr_ready  in  1  downstream accepts when instr_valid & instr_ready

## Operation
- A halfword is compressed iff h[1:0] != 2'b11.
- advance = ~instr_valid | instr_ready. The output register loads only when advance is set and a new instruction is produced.
- Internal state:
  - buf_state ∈ {EMPTY, HALF}
  - buf_h[15:0], buf_pc[31:0]
  - skip_low flag
- EMPTY, skip_low = 0, word accepted (addr A, data D):
  - D[15:0] compressed: emit {16'b0, D[15:0]} at pc A, is_c = 1. buf_h ← D[31:16], buf_pc ← A+2, go to HALF.
  - Otherwise: emit D at pc A, is_c = 0, stay in EMPTY.
- EMPTY, skip_low = 1, word accepted: discard D[15:0] and clear skip_low.
  - D[31:16] compressed: emit it at pc A+2, stay in EMPTY.
  - Otherwise: buf_h ← D[31:16], buf_pc ← A+2, go to HALF, emit nothing.
- HALF, buf_h compressed:
  - Emit buf_h at buf_pc and go to EMPTY.
  - fetch_ready = 0; no word is consumed.
- HALF, buf_h not compressed:
  - Requires a fetch word. Emit {D[15:0], buf_h} at buf_pc, is_c = 0.
  - buf_h ← D[31:16], buf_pc ← A+2, stay in HALF.
- fetch_ready = advance & ~flush & ~(buf_state == HALF & buf_h compressed).
- If nothing is emitted in a cycle where advance is set: instr_valid ← 0 (the bubble is cleared).
- flush has highest priority:
  - instr_valid ← 0, buf_state ← EMPTY, skip_low ← redirect_pc[1].
  - fetch_ready = 0 that cycle.
  - The first word accepted after flush must be at redirect_pc & ~3.

## Timing
- Reset values: instr_valid = 0, instr = 0, instr_pc = 0, instr_is_c = 0, buf_state = EMPTY, skip_low = 0. fetch_ready is combinational: 1 after reset when instr_valid = 0.
- Latency: word accepted in cycle N → instruction visible in cycle N+1.
- Throughput: one instruction per cycle. Two compressed instructions in one word take two cycles and consume one fetch slot.
- Downstream backpressure (instr_valid & ~instr_ready): the output register, buffer and skip_low all hold, and fetch_ready = 0.
- flush with instr_valid & instr_ready set in the same cycle: the handshake completes and the output is invalidated next cycle; the instruction is not re-presented.
- Reset asserted mid-operation: asynchronous return to the reset values and the buffer contents are lost. The first word accepted after reset is treated with skip_low = 0.

## Structure
- Package realign_pkg holds:
  - typedef enum logic {EMPTY, HALF} buf_state_t
  - typedef logic [15:0] half_t
  - function is_compressed(half_t)
  - localparam HALF_BYTES = 2
- Sub-module instr_out_reg: valid/ready pipeline register carrying {instr, instr_pc, instr_is_c}, with a clear input driven by flush.
- The top level holds the buffer, the skip logic and the emit/consume mux.

## Test plan
- Reset, then word 0x00B3_0513 (addi, not compressed) at 0x0 → instr = 0x00B30513, pc 0x0, is_c = 0; buffer stays EMPTY.
- Word 0x4505_4585 at 0x4 → cycle 1: instr 0x4585 at pc 0x4, is_c = 1. Cycle 2: 0x4505 at pc 0x6 with fetch_ready = 0.
- Straddle:
  - Word 0x0513_4585 at 0x8 → emit 0x4585 at pc 0x8; buffer holds 0x0513.
  - Next word 0xXXXX_00B3 at 0xC → emit 0x00B30513 at pc 0xA.
- flush with redirect_pc = 0x102, then word 0x4585_1234 at 0x100 → only 0x4585 is emitted, at pc 0x102; 0x1234 is discarded.
- instr_ready held at 0 for 3 cycles with a buffered compressed halfword → instr and buffer are stable, fetch_ready = 0; the sequence resumes unchanged on release.
- reset_n asserted while in HALF with instr_valid = 1 → instr_valid = 0 immediately. After release, word 0x00B30513 at 0x20 is emitted whole at pc 0x20.
